count_display: RTL and testbench



---
 rtl/count_display_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 71 +++++++
 rtl/count_display.sv | 80 ++++++++
 tb/tb_count_display.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count_display block: conversion FSM states,
// digit geometry and the active-low seven-segment pattern table.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int DIGITS   = 3;
    localparam int NIBBLE_W = 4;
    localparam int BIN_W    = 8;
    localparam int BCD_W    = DIGITS * NIBBLE_W;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    // Active-low {g,f,e,d,c,b,a}; leftmost entry is digit 9, rightmost is digit 0.
    localparam logic [9:0][6:0] SEG_PATTERNS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [NIBBLE_W-1:0] digit);
        if (digit > 4'd9) begin
            return SEG_OFF;
        end
        return SEG_PATTERNS[digit];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: captures a new binary value only from IDLE,
// runs eight shift-add-3 iterations, then publishes the BCD result.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] value,
    output logic [BCD_W-1:0] bcd,
    output logic             busy
);

    conv_state_t      state;
    logic [BIN_W-1:0] last_bin;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] adjusted;
    logic [2:0]       iter;

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
                adjusted[i*NIBBLE_W +: NIBBLE_W] = scratch[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_bin <= '0;
            bin_sr   <= '0;
            scratch  <= '0;
            iter     <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Changes that arrive mid-conversion are picked up here afterwards.
                    if (value != last_bin) begin
                        bin_sr   <= value;
                        last_bin <= value;
                        scratch  <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adjusted[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    iter    <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= scratch;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/count_display.sv
// Three-digit multiplexed seven-segment driver for the 8-bit button count, with
// optional leading-zero blanking on the hundreds and tens slots.
module count_display
    import count_display_pkg::*;
#(
    parameter int REFRESH     = 50000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] value,
    output logic [6:0]       seg,
    output logic [2:0]       an,
    output logic [BCD_W-1:0] bcd,
    output logic             busy
);

    localparam int CNT_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH - 1);

    logic [CNT_W-1:0]    refresh_cnt;
    logic [1:0]          digit_idx;
    logic [NIBBLE_W-1:0] digit;
    logic                blank;
    logic                hundreds_zero;
    logic                tens_zero;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .bcd   (bcd),
        .busy  (busy)
    );

    assign hundreds_zero = (bcd[11:8] == 4'd0);
    assign tens_zero     = (bcd[7:4] == 4'd0);

    always_comb begin
        digit = '0;
        blank = 1'b0;
        case (digit_idx)
            2'd0: digit = bcd[3:0];
            2'd1: begin
                digit = bcd[7:4];
                blank = BLANK_ZEROS && hundreds_zero && tens_zero;
            end
            2'd2: begin
                digit = bcd[11:8];
                blank = BLANK_ZEROS && hundreds_zero;
            end
            default: blank = 1'b1;
        endcase
    end

    // Outputs are registered from the current slot, so they trail digit_idx/bcd by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (blank) begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
            end else begin
                seg <= seg_decode(digit);
                an  <= ~(3'b001 << digit_idx);
            end
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with REFRESH=4: one instance blanks leading
// zeros, a second instance always shows all three digits.
module tb_count_display;

    localparam int R = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  value;
    logic [6:0]  seg,    seg_nb;
    logic [2:0]  an,     an_nb;
    logic [11:0] bcd,    bcd_nb;
    logic        busy,   busy_nb;

    int total;
    int bad;
    int cyc;
    int slot;

    logic [6:0] exp_seg[3];
    logic [2:0] exp_an[3];
    logic [6:0] exp_seg_nb[3];
    logic [2:0] exp_an_nb[3];

    count_display #(.REFRESH(R), .BLANK_ZEROS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .busy  (busy)
    );

    count_display #(.REFRESH(R), .BLANK_ZEROS(1'b0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg_nb),
        .an    (an_nb),
        .bcd   (bcd_nb),
        .busy  (busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts edges since the last edge taken with reset high.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc = reset ? 0 : cyc + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value = 8'd0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || bcd !== 12'h000 || an !== 3'b111 || seg !== 7'h7F) begin
            bad++;
            $display("FAIL reset_state: busy=%b bcd=%h an=%b seg=%h, need 0 000 111 7f", busy, bcd, an, seg);
        end
        reset = 1'b0;
        tick();
        exp_seg = '{7'h40, 7'h7F, 7'h7F};
        exp_an  = '{3'b110, 3'b111, 3'b111};
        exp_seg_nb = '{7'h40, 7'h40, 7'h40};
        exp_an_nb  = '{3'b110, 3'b101, 3'b011};
        for (int k = 0; k < 3 * R; k++) begin
            slot = ((cyc - 1) / R) % 3;
            total++;
            if (seg !== exp_seg[slot] || an !== exp_an[slot] || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_scan cyc=%0d: an=%b seg=%h busy=%b, need an=%b seg=%h busy=0",
                         cyc, an, seg, busy, exp_an[slot], exp_seg[slot]);
            end
            total++;
            if (seg_nb !== exp_seg_nb[slot] || an_nb !== exp_an_nb[slot]) begin
                bad++;
                $display("FAIL reset_scan_noblank cyc=%0d: an=%b seg=%h, need an=%b seg=%h",
                         cyc, an_nb, seg_nb, exp_an_nb[slot], exp_seg_nb[slot]);
            end
            tick();
        end
    endtask

    task automatic test_convert_255();
        value = 8'd255;
        tick();
        for (int k = 1; k <= 9; k++) begin
            total++;
            if (busy !== 1'b1 || bcd !== 12'h000) begin
                bad++;
                $display("FAIL conv255_busy T+%0d: busy=%b bcd=%h, need busy=1 bcd=000", k, busy, bcd);
            end
            if (k < 9) tick();
        end
        tick();
        total++;
        if (busy !== 1'b0 || bcd !== 12'h255) begin
            bad++;
            $display("FAIL conv255_done: busy=%b bcd=%h, need busy=0 bcd=255", busy, bcd);
        end
        tick();
        exp_seg = '{7'h12, 7'h12, 7'h24};
        exp_an  = '{3'b110, 3'b101, 3'b011};
        for (int k = 0; k < 3 * R; k++) begin
            slot = ((cyc - 1) / R) % 3;
            total++;
            if (seg !== exp_seg[slot] || an !== exp_an[slot]) begin
                bad++;
                $display("FAIL conv255_scan cyc=%0d: an=%b seg=%h, need an=%b seg=%h",
                         cyc, an, seg, exp_an[slot], exp_seg[slot]);
            end
            tick();
        end
    endtask

    task automatic test_blank_7();
        value = 8'd7;
        for (int k = 0; k < 11; k++) tick();
        total++;
        if (bcd !== 12'h007 || bcd_nb !== 12'h007) begin
            bad++;
            $display("FAIL blank7_bcd: bcd=%h bcd_nb=%h, need 007", bcd, bcd_nb);
        end
        exp_seg = '{7'h78, 7'h7F, 7'h7F};
        exp_an  = '{3'b110, 3'b111, 3'b111};
        exp_seg_nb = '{7'h78, 7'h40, 7'h40};
        exp_an_nb  = '{3'b110, 3'b101, 3'b011};
        for (int k = 0; k < 3 * R; k++) begin
            slot = ((cyc - 1) / R) % 3;
            total++;
            if (seg !== exp_seg[slot] || an !== exp_an[slot]) begin
                bad++;
                $display("FAIL blank7_scan cyc=%0d: an=%b seg=%h, need an=%b seg=%h",
                         cyc, an, seg, exp_an[slot], exp_seg[slot]);
            end
            total++;
            if (seg_nb !== exp_seg_nb[slot] || an_nb !== exp_an_nb[slot]) begin
                bad++;
                $display("FAIL blank7_scan_noblank cyc=%0d: an=%b seg=%h, need an=%b seg=%h",
                         cyc, an_nb, seg_nb, exp_an_nb[slot], exp_seg_nb[slot]);
            end
            tick();
        end
    endtask

    task automatic test_tens_zero_105();
        value = 8'd105;
        for (int k = 0; k < 11; k++) tick();
        total++;
        if (bcd !== 12'h105) begin
            bad++;
            $display("FAIL tens0_bcd: bcd=%h, need 105", bcd);
        end
        exp_seg = '{7'h12, 7'h40, 7'h79};
        exp_an  = '{3'b110, 3'b101, 3'b011};
        for (int k = 0; k < 3 * R; k++) begin
            slot = ((cyc - 1) / R) % 3;
            total++;
            if (seg !== exp_seg[slot] || an !== exp_an[slot]) begin
                bad++;
                $display("FAIL tens0_scan cyc=%0d: an=%b seg=%h, need an=%b seg=%h",
                         cyc, an, seg, exp_an[slot], exp_seg[slot]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        value = 8'd200;
        tick();
        for (int k = 0; k < 3; k++) tick();
        value = 8'd99;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (bcd !== 12'h200 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: bcd=%h busy=%b, need bcd=200 busy=0", bcd, busy);
        end
        tick();
        total++;
        if (busy !== 1'b1 || bcd !== 12'h200) begin
            bad++;
            $display("FAIL b2b_recapture: busy=%b bcd=%h, need busy=1 bcd=200", busy, bcd);
        end
        for (int k = 0; k < 9; k++) tick();
        total++;
        if (bcd !== 12'h099 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: bcd=%h busy=%b, need bcd=099 busy=0", bcd, busy);
        end
    endtask

    task automatic test_reset_mid();
        value = 8'd42;
        tick();
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || bcd !== 12'h000 || an !== 3'b111 || seg !== 7'h7F) begin
            bad++;
            $display("FAIL midreset_state: busy=%b bcd=%h an=%b seg=%h, need 0 000 111 7f", busy, bcd, an, seg);
        end
        total++;
        if (an_nb !== 3'b111 || seg_nb !== 7'h7F) begin
            bad++;
            $display("FAIL midreset_noblank: an=%b seg=%h, need 111 7f", an_nb, seg_nb);
        end
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || an !== 3'b110 || seg !== 7'h40) begin
            bad++;
            $display("FAIL midreset_restart: busy=%b an=%b seg=%h, need busy=1 an=110 seg=40", busy, an, seg);
        end
        for (int k = 0; k < 9; k++) tick();
        total++;
        if (bcd !== 12'h042 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_reconvert: bcd=%h busy=%b, need bcd=042 busy=0", bcd, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        value = 8'd0;
        test_reset();
        test_convert_255();
        test_blank_7();
        test_tens_zero_105();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
